// File: rtl/microprocessor_keys_pkg.sv
// Shared definitions for the pushbutton event controller.
//   ADDR_*     Avalon word addresses of the four registers
//   COUNT_MAX  saturation value of the press counter
//   bus_req_t  decoded slave write request
package microprocessor_keys_pkg;
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_COUNT   = 2'd1;
   localparam logic [1:0] ADDR_MASK    = 2'd2;
   localparam logic [1:0] ADDR_CAPTURE = 2'd3;

   localparam logic [7:0] COUNT_MAX = 8'd255;

   typedef struct packed {
      logic        we;
      logic [1:0]  addr;
      logic [31:0] wdata;
   } bus_req_t;
endpackage

// File: rtl/key_debounce.sv
// One pushbutton channel: 2-FF synchroniser, debounce counter, press edge detect.
//   clk, reset_n  system clock, async active-low reset
//   raw_n         raw key, active-low, asynchronous to clk
//   level_n       debounced level (1 = released)
//   press_pulse   one-cycle pulse, coincident with level_n falling
module key_debounce #(
   parameter int DEBOUNCE_CYC = 50000,
   parameter int CNT_W        = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw_n,
   output logic level_n,
   output logic press_pulse
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt;
   logic             s;

   assign s = sync_q[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q      <= 2'b11;
         level_n     <= 1'b1;
         cnt         <= '0;
         press_pulse <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], raw_n};
         press_pulse <= 1'b0;
         if (s == level_n) begin
            // Any bounce back to the accepted level restarts qualification.
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level_n     <= s;
            cnt         <= '0;
            press_pulse <= ~s;  // only the 1->0 transition is an event
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/microprocessor_keys_event_ctrl.sv
// Avalon-MM slave conditioning active-low pushbuttons into press events + IRQ.
//   clk, reset_n                     system clock, async active-low reset
//   address, chipselect, write_n,    Avalon slave write/read port
//   writedata, readdata              (readdata registered, latency 1)
//   irq                              level interrupt, |(capture & mask), registered
//   in_port                          raw keys, active-low
// Registers: 0 DATA (~debounced), 1 COUNT (press cycles, sat 255, write clears),
//            2 MASK, 3 CAPTURE (sticky, W1C, set wins over clear).
module microprocessor_keys_event_ctrl
   import microprocessor_keys_pkg::*;
#(
   parameter int WIDTH        = 4,
   parameter int DEBOUNCE_CYC = 50000,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq,
   input  logic [WIDTH-1:0] in_port
);
   logic [WIDTH-1:0] level_n;
   logic [WIDTH-1:0] press;
   logic [WIDTH-1:0] capture;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] clr;
   logic [7:0]       press_cnt;
   logic [31:0]      rd_nxt;
   bus_req_t         req;
   logic             unused_wdata;

   for (genvar g = 0; g < WIDTH; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .CNT_W        (CNT_W)
      ) u_key (
         .clk         (clk),
         .reset_n     (reset_n),
         .raw_n       (in_port[g]),
         .level_n     (level_n[g]),
         .press_pulse (press[g])
      );
   end

   assign req.we       = chipselect & ~write_n;
   assign req.addr     = address;
   assign req.wdata    = writedata;
   assign unused_wdata = ^writedata;

   assign clr = (req.we && req.addr == ADDR_CAPTURE) ? req.wdata[WIDTH-1:0] : '0;

   always_comb begin
      rd_nxt = '0;
      case (address)
         ADDR_DATA:    rd_nxt[WIDTH-1:0] = ~level_n;
         ADDR_COUNT:   rd_nxt[7:0]       = press_cnt;
         ADDR_MASK:    rd_nxt[WIDTH-1:0] = mask;
         ADDR_CAPTURE: rd_nxt[WIDTH-1:0] = capture;
         default:      rd_nxt            = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         capture   <= '0;
         mask      <= '0;
         press_cnt <= '0;
         readdata  <= '0;
         irq       <= 1'b0;
      end else begin
         readdata <= rd_nxt;
         // New events are OR'd in after the clear so a same-cycle press survives.
         capture  <= (capture & ~clr) | press;
         irq      <= |(capture & mask);
         if (req.we && req.addr == ADDR_MASK)
            mask <= req.wdata[WIDTH-1:0];
         if (req.we && req.addr == ADDR_COUNT)
            press_cnt <= '0;
         else if (|press && press_cnt != COUNT_MAX)
            press_cnt <= press_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_microprocessor_keys_event_ctrl.sv
module tb_microprocessor_keys_event_ctrl;
   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;
   logic [3:0]  in_port;

   int checks = 0;
   int errors = 0;
   logic [31:0] rv;

   microprocessor_keys_event_ctrl #(
      .WIDTH        (4),
      .DEBOUNCE_CYC (4),
      .CNT_W        (16)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .in_port    (in_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      tick();
      d = readdata;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   initial begin
      reset_n    = 1'b0;
      in_port    = 4'hF;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;

      // 1. reset
      wait_n(3);
      chk("rst_readdata", readdata, 0);
      chk("rst_irq", {31'd0, irq}, 0);
      reset_n = 1'b1;
      rd(2'd0, rv); chk("rst_data", rv, 0);
      rd(2'd3, rv); chk("rst_capture", rv, 0);
      rd(2'd1, rv); chk("rst_count", rv, 0);
      chk("rst_irq2", {31'd0, irq}, 0);

      // 2. key0 press: 2 sync + 4 debounce edges to accept, +1 read latency
      address = 2'd0;
      in_port = 4'hE;
      wait_n(6);
      chk("t2_data_early", readdata, 0);
      tick();
      chk("t2_data", readdata, 1);
      rd(2'd3, rv); chk("t2_capture", rv, 1);
      rd(2'd1, rv); chk("t2_count", rv, 1);
      in_port = 4'hF;
      wait_n(10);
      rd(2'd0, rv); chk("t2_release", rv, 0);
      rd(2'd1, rv); chk("t2_no_release_evt", rv, 1);
      wr(2'd3, 32'hF);
      wr(2'd1, 32'h0);
      rd(2'd3, rv); chk("t2_cap_clr", rv, 0);

      // 3. bouncing key1 never qualifies
      address = 2'd0;
      for (int i = 0; i < 5; i++) begin
         in_port = 4'hD; wait_n(2);
         in_port = 4'hF; wait_n(2);
         chk("t3_data_bounce", readdata, 0);
      end
      wait_n(10);
      rd(2'd0, rv); chk("t3_data", rv, 0);
      rd(2'd3, rv); chk("t3_capture", rv, 0);
      rd(2'd1, rv); chk("t3_count", rv, 0);

      // 4. mask + irq
      wr(2'd2, 32'h4);
      rd(2'd2, rv); chk("t4_mask", rv, 4);
      address = 2'd3;
      in_port = 4'hB;
      wait_n(7);
      chk("t4_cap_before", readdata, 0);
      chk("t4_irq_before", {31'd0, irq}, 0);
      tick();
      chk("t4_cap_set", readdata, 4);
      chk("t4_irq_set", {31'd0, irq}, 1);
      wr(2'd3, 32'h4);
      tick();
      chk("t4_irq_clr", {31'd0, irq}, 0);
      rd(2'd3, rv); chk("t4_cap_clr", rv, 0);
      in_port = 4'hF;
      wait_n(10);
      in_port = 4'hB;
      wait_n(6);
      wr(2'd3, 32'h4);  // lands on the same edge as the press pulse
      rd(2'd3, rv); chk("t4_set_wins", rv, 4);
      chk("t4_irq_again", {31'd0, irq}, 1);
      in_port = 4'hF;
      wait_n(10);
      wr(2'd3, 32'hF);
      wr(2'd1, 32'h0);

      // 5. simultaneous keys, saturation, clear
      in_port = 4'h6;
      wait_n(10);
      rd(2'd3, rv); chk("t5_capture", rv, 9);
      rd(2'd1, rv); chk("t5_count", rv, 1);
      chk("t5_irq_masked", {31'd0, irq}, 0);
      in_port = 4'hF;
      wait_n(10);
      for (int i = 0; i < 260; i++) begin
         in_port = 4'hE; wait_n(8);
         in_port = 4'hF; wait_n(8);
      end
      rd(2'd1, rv); chk("t5_count_sat", rv, 255);
      wr(2'd1, 32'h0);
      rd(2'd1, rv); chk("t5_count_clr", rv, 0);
      in_port = 4'hD;
      wait_n(6);
      wr(2'd1, 32'h0);  // same edge as the press pulse: write wins
      rd(2'd1, rv); chk("t5_write_wins", rv, 0);
      in_port = 4'hF;
      wait_n(10);

      // 6. reset mid-debounce
      wr(2'd2, 32'hF);
      tick();
      chk("t6_irq_pre", {31'd0, irq}, 1);
      rd(2'd3, rv); chk("t6_cap_pre", rv, 32'hB);
      in_port = 4'h7;
      wait_n(3);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_readdata", readdata, 0);
      chk("t6_rst_irq", {31'd0, irq}, 0);
      wait_n(2);
      reset_n = 1'b1;
      rd(2'd2, rv); chk("t6_mask_rst", rv, 0);
      wait_n(10);
      rd(2'd0, rv); chk("t6_requalify", rv, 8);
      in_port = 4'hF;
      wait_n(10);
      rd(2'd0, rv); chk("t6_released", rv, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
